qupls_mc_sequencer: RTL
=======================

Name: qupls_mc_sequencer

Overview:
- Programmable micro-code entry table plus micro-PC sequencer for the Qupls decode stage.
- Matches an instruction key against NENT key/mask entries to obtain the micro-code entry address, then steps the micro-PC through the external asynchronous micro-code ROM.
- Supports sequential, jump, call and return micro-ops with a bounded return stack.
- Non-microcoded instructions are flagged as pass-through.

Parameters:
- MC_AW, 12, micro-code address width; matches mc_address_t.
- KEYW, 16, instruction key width: opcode plus function/size bits chosen by decode.
- NENT, 16, number of entry-table slots.
- STK_DEPTH, 4, return-stack depth.
- CNTW, 16, width of the issued micro-op counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cfg_we  in  1  entry-table write strobe.
- cfg_idx  in  $clog2(NENT)  slot written.
- cfg_valid  in  1  slot valid bit.
- cfg_key  in  KEYW  slot match key.
- cfg_mask  in  KEYW  slot match mask; 1 = bit compared.
- cfg_addr  in  MC_AW  slot entry address.
- in_valid  in  1  instruction key offered.
- in_ready  out  1  sequencer can accept a key.
- in_key  in  KEYW  instruction key.
- pass_o  out  1  one-cycle pulse: the accepted key missed the table.
- mip  out  MC_AW  current micro-code address to the ROM.
- mip_valid  out  1  mip holds a live micro-instruction.
- out_ready  in  1  downstream consumes the micro-instruction at mip.
- uc_op  in  2  ROM field for mip: 0 seq, 1 jump, 2 call, 3 return.
- uc_target  in  MC_AW  ROM jump/call target for mip.
- uc_last  in  1  ROM: mip is the final micro-instruction.
- flush  in  1  abort the current sequence.
- err_clr  in  1  clear sticky errors.
- err_ovf  out  1  sticky return-stack overflow.
- err_unf  out  1  sticky return-stack underflow.
- active  out  1  state is RUN.
- uop_count  out  CNTW  issued micro-instruction count.

Behaviour:
- Clocking and reset
  - One clock; reset is synchronous and active-high.
  - On rst: all slots invalid, state IDLE, mip=0, mip_valid=0, pass_o=0, stack pointer 0, err_ovf=err_unf=0, uop_count=0.
  - in_ready=0 during the rst cycle.
- Ready and accept
  - in_ready = (state==IDLE) && !flush && !rst.
  - A key is accepted when in_valid && in_ready.
- Lookup
  - Combinational.
  - Hit on slot i when valid[i] && ((in_key ^ key[i]) & mask[i]) == 0.
  - The lowest index wins.
- Accept results
  - Hit: next cycle state=RUN, mip=addr[i], mip_valid=1, stack cleared.
  - Miss: next cycle pass_o=1 for exactly one cycle; state stays IDLE.
- Table writes
  - Permitted in any state. The write is visible to lookups from the next cycle.
  - A same-cycle lookup sees the old contents.
  - A running sequence is unaffected.
- RUN with out_ready=0: hold mip and stack; mip_valid stays 1.
- RUN with out_ready=1
  - uop_count increments, wrapping at 2^CNTW.
  - If uc_last: state IDLE next cycle, mip_valid=0, stack cleared, uc_op ignored.
  - Otherwise, by uc_op:
    - seq: mip <= mip+1, wrapping modulo 2^MC_AW.
    - jump: mip <= uc_target.
    - call: push mip+1, then mip <= uc_target.
      - If the stack holds STK_DEPTH entries: set err_ovf, abort to IDLE, mip_valid=0.
    - return: pop into mip.
      - If the stack is empty: set err_unf, abort to IDLE.
- Flush
  - flush (below rst in priority) forces IDLE, mip_valid=0 and stack clear next cycle.
  - uop_count does not increment for the micro-instruction present in the flush cycle.
- Errors
  - err_clr clears both error flags next cycle.
  - An error event in the same cycle as err_clr wins, so the flag is set.
- Back-to-back keys
  - A new key can be accepted in the cycle after the sequence returns to IDLE.
  - Minimum sequence turnaround is 1 IDLE cycle.

Decomposition:
- QuplsPkg gains:
  - mc_op_t enum (MC_SEQ, MC_JMP, MC_CALL, MC_RET).
  - mcat_entry_t struct {valid, key, mask, addr}.
- Sub-module qupls_mcat_lookup holds the combinational key/mask priority match. Outputs: hit, index, addr.
- The sequencer holds the slot registers, FSM, stack and counter.

Test Plan:
- Slot 3 = {key 16'h0041, mask 16'h007F, addr 12'h040}; key 16'h1241 with out_ready=1 → mip 040, 041, 042. uc_last at 042 → IDLE; uop_count=3.
- Slots 2 and 5 both match key 16'h0020 (addr 020 and 300) → slot 2 wins; mip=020 the cycle after accept.
- Call chain: call at 050 to 0C0, call at 0C0 to 0E0, return, return → mip 050, 0C0, 0E0, 0C1, 051. Five calls with STK_DEPTH=4 → err_ovf=1, IDLE.
- Miss on key 16'h0007 with all slots invalid → pass_o high one cycle; state stays IDLE; in_ready stays 1.
- out_ready=0 for 3 cycles mid-sequence at mip=0A2 → mip holds 0A2; uop_count unchanged. flush next cycle → mip_valid=0; in_ready=1 one cycle later.
- cfg write to slot 0 in the same cycle as an accept of a matching key → old contents used; a second key after IDLE hits the new addr. rst asserted during RUN → all outputs return to reset values.

Source files
------------

// File: rtl/qupls_mc_sequencer_pkg.sv
// Shared types for the Qupls micro-code entry table and micro-PC sequencer.
package qupls_mc_sequencer_pkg;

  localparam int unsigned MC_AW = 12;
  localparam int unsigned KEYW  = 16;

  typedef logic [MC_AW-1:0] mc_address_t;
  typedef logic [KEYW-1:0]  mc_key_t;

  typedef enum logic [1:0] {
    MC_SEQ  = 2'd0,
    MC_JMP  = 2'd1,
    MC_CALL = 2'd2,
    MC_RET  = 2'd3
  } mc_op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_t;

  typedef struct packed {
    logic        valid;
    mc_key_t     key;
    mc_key_t     mask;
    mc_address_t addr;
  } mcat_entry_t;

  // A mask bit of 1 means that key bit takes part in the comparison.
  function automatic logic key_match(input mcat_entry_t e, input mc_key_t k);
    return e.valid && (((k ^ e.key) & e.mask) == '0);
  endfunction

endpackage

// File: rtl/qupls_mcat_lookup.sv
// Combinational key/mask priority match over the entry table; lowest slot wins.
module qupls_mcat_lookup
  import qupls_mc_sequencer_pkg::*;
#(
  parameter int unsigned NENT = 16,
  parameter int unsigned IW   = $clog2(NENT)
) (
  input  mcat_entry_t [NENT-1:0] entries,
  input  logic [KEYW-1:0]        key,
  output logic                   hit,
  output logic [IW-1:0]          index,
  output logic [MC_AW-1:0]       addr
);

  // Scan high to low so the lowest matching slot overwrites the result last.
  always_comb begin
    hit   = 1'b0;
    index = '0;
    addr  = '0;
    for (int i = int'(NENT) - 1; i >= 0; i--) begin
      if (key_match(entries[i], key)) begin
        hit   = 1'b1;
        index = IW'(i);
        addr  = entries[i].addr;
      end
    end
  end

endmodule

// File: rtl/qupls_mc_sequencer.sv
// Micro-code entry table plus micro-PC sequencer with a bounded return stack.
module qupls_mc_sequencer
  import qupls_mc_sequencer_pkg::*;
#(
  parameter int unsigned NENT      = 16,
  parameter int unsigned STK_DEPTH = 4,
  parameter int unsigned CNTW      = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_we,
  input  logic [$clog2(NENT)-1:0]  cfg_idx,
  input  logic                     cfg_valid,
  input  logic [KEYW-1:0]          cfg_key,
  input  logic [KEYW-1:0]          cfg_mask,
  input  logic [MC_AW-1:0]         cfg_addr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [KEYW-1:0]          in_key,
  output logic                     pass_o,
  output logic [MC_AW-1:0]         mip,
  output logic                     mip_valid,
  input  logic                     out_ready,
  input  logic [1:0]               uc_op,
  input  logic [MC_AW-1:0]         uc_target,
  input  logic                     uc_last,
  input  logic                     flush,
  input  logic                     err_clr,
  output logic                     err_ovf,
  output logic                     err_unf,
  output logic                     active,
  output logic [CNTW-1:0]          uop_count
);

  localparam int unsigned IW  = $clog2(NENT);
  localparam int unsigned SPW = $clog2(STK_DEPTH + 1);
  localparam int unsigned SIW = (STK_DEPTH > 1) ? $clog2(STK_DEPTH) : 1;

  mcat_entry_t [NENT-1:0] slots;
  seq_state_t             state, state_nxt;
  logic [MC_AW-1:0]       stk [STK_DEPTH];
  logic [SPW-1:0]         sp, sp_nxt;
  logic [MC_AW-1:0]       mip_nxt, mip_inc;
  logic                   push;

  logic                   lk_hit;
  logic [IW-1:0]          lk_idx;
  logic [MC_AW-1:0]       lk_addr;

  logic                   accept, consume, stk_full, stk_empty, call_ovf, ret_unf;
  mc_op_t                 op;

  qupls_mcat_lookup #(
    .NENT (NENT),
    .IW   (IW)
  ) u_lookup (
    .entries (slots),
    .key     (in_key),
    .hit     (lk_hit),
    .index   (lk_idx),
    .addr    (lk_addr)
  );

  assign accept    = in_valid && in_ready;
  assign consume   = (state == ST_RUN) && !flush && out_ready;
  assign op        = mc_op_t'(uc_op);
  assign stk_full  = (sp == SPW'(STK_DEPTH));
  assign stk_empty = (sp == '0);
  assign mip_inc   = mip + MC_AW'(1);
  assign call_ovf  = consume && !uc_last && (op == MC_CALL) && stk_full;
  assign ret_unf   = consume && !uc_last && (op == MC_RET) && stk_empty;

  // Table writes land at the clock edge, so a same-cycle lookup sees old contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      slots <= '0;
    end else if (cfg_we) begin
      slots[cfg_idx] <= '{valid: cfg_valid, key: cfg_key, mask: cfg_mask, addr: cfg_addr};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (accept && lk_hit) state_nxt = ST_RUN;
      ST_RUN: begin
        if (flush)                                             state_nxt = ST_IDLE;
        else if (consume && (uc_last || call_ovf || ret_unf))  state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == ST_IDLE) && !flush && !rst;
    active   = (state == ST_RUN);
  end

  // Micro-PC and return-stack pointer advance; aborts leave mip as-is.
  always_comb begin
    mip_nxt = mip;
    sp_nxt  = sp;
    push    = 1'b0;
    if (accept && lk_hit) begin
      mip_nxt = lk_addr;
      sp_nxt  = '0;
    end else if (state == ST_RUN) begin
      if (flush || (consume && uc_last)) begin
        sp_nxt = '0;
      end else if (consume) begin
        unique case (op)
          MC_SEQ: mip_nxt = mip_inc;
          MC_JMP: mip_nxt = uc_target;
          MC_CALL: begin
            if (stk_full) begin
              sp_nxt = '0;
            end else begin
              push    = 1'b1;
              sp_nxt  = sp + SPW'(1);
              mip_nxt = uc_target;
            end
          end
          MC_RET: begin
            if (stk_empty) begin
              sp_nxt = '0;
            end else begin
              sp_nxt  = sp - SPW'(1);
              mip_nxt = stk[SIW'(sp - SPW'(1))];
            end
          end
          default: mip_nxt = mip;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mip       <= '0;
      mip_valid <= 1'b0;
      pass_o    <= 1'b0;
      sp        <= '0;
      err_ovf   <= 1'b0;
      err_unf   <= 1'b0;
      uop_count <= '0;
    end else begin
      mip       <= mip_nxt;
      mip_valid <= (state_nxt == ST_RUN);
      pass_o    <= accept && !lk_hit;
      sp        <= sp_nxt;
      err_ovf   <= call_ovf || (err_ovf && !err_clr);
      err_unf   <= ret_unf  || (err_unf && !err_clr);
      if (consume) uop_count <= uop_count + CNTW'(1);
    end
  end

  // Stack storage needs no reset: the pointer alone defines what is live.
  always_ff @(posedge clk) begin
    if (push) stk[SIW'(sp)] <= mip_inc;
  end

  // The lookup's address and index must name the same slot.
  always @(posedge clk) begin
    if (!rst && accept && lk_hit) begin
      assert (lk_addr == slots[lk_idx].addr);
    end
  end

endmodule
